// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester round-robin front end for a shared combinational ALU.
// A granted request has its operands and opcode registered and driven to the ALU.
// They are held for SETTLE_CYCLES cycles, and then the ALU result is captured.
// The captured result is presented as a response that waits for rsp_ready.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   req{0,1}_valid / _ready        request handshake (ready is combinational)
//   req{0,1}_a, _b (4b), _sel (3b) operands and opcode per requester
//   alu_a, alu_b, alu_sel          registered operands/opcode driven to the ALU
//   alu_out (8b), alu_cflag/zflag  ALU result inputs
//   rsp_valid / rsp_ready          response handshake
//   rsp_id, rsp_out, rsp_cflag, rsp_zflag, rsp_err   captured response
//   busy                           high whenever the FSM is not idle
//   op_count (8b)                  completed responses, wraps at 256
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req0_sel,
    input  logic [2:0] req1_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_out,
    input  logic       alu_cflag,
    input  logic       alu_zflag,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_out,
    output logic       rsp_cflag,
    output logic       rsp_zflag,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] op_count
);

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYCLES);
    localparam logic [2:0] OP_DIV    = 3'b011;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;      // requester preferred when both are valid
    logic       run_q;             // keeps ready low until the first edge after reset release
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       id_q, id_d;
    logic [7:0] out_q, out_d;
    logic       c_q, c_d, z_q, z_d, err_q, err_d;
    logic [7:0] opcnt_q, opcnt_d;

    logic gnt;
    logic accept;
    logic div_zero;

    // Lone requester wins outright; on contention the pointer decides.
    assign gnt        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    assign req0_ready = run_q && (state_q == IDLE) && req0_valid && !gnt;
    assign req1_ready = run_q && (state_q == IDLE) && req1_valid &&  gnt;
    assign accept     = req0_ready || req1_ready;
    assign div_zero   = (sel_q == OP_DIV) && (b_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        id_d    = id_q;
        out_d   = out_q;
        c_d     = c_q;
        z_d     = z_q;
        err_d   = err_q;
        opcnt_d = opcnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LD;
                    id_d    = gnt;
                    a_d     = gnt ? req1_a   : req0_a;
                    b_d     = gnt ? req1_b   : req0_b;
                    sel_d   = gnt ? req1_sel : req0_sel;
                end
            end
            SETTLE: begin
                // Capture once the counter has been seen at zero, giving
                // SETTLE_CYCLES+1 edges from acceptance to a valid response.
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    out_d   = div_zero ? 8'h00 : alu_out;
                    c_d     = div_zero ? 1'b0  : alu_cflag;
                    z_d     = div_zero ? 1'b0  : alu_zflag;
                    err_d   = div_zero;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~id_q;
                    opcnt_d = opcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ptr_q   <= 1'b0;
            run_q   <= 1'b0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            sel_q   <= 3'd0;
            id_q    <= 1'b0;
            out_q   <= 8'd0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            opcnt_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            run_q   <= 1'b1;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            id_q    <= id_d;
            out_q   <= out_d;
            c_q     <= c_d;
            z_q     <= z_d;
            err_q   <= err_d;
            opcnt_q <= opcnt_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_out   = out_q;
    assign rsp_cflag = c_q;
    assign rsp_zflag = z_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = opcnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a stub ALU, a response scoreboard, and a second
// instance with SETTLE_CYCLES=3 for the longer settle latency.
module tb_alu_arbiter;
    localparam int S  = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_sel = 0, req1_sel = 0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_cflag, alu_zflag;
    logic       rsp_valid, rsp_ready = 1, rsp_id, rsp_cflag, rsp_zflag, rsp_err, busy;
    logic [7:0] rsp_out, op_count;

    // SETTLE_CYCLES=3 instance signals
    logic       d3_req0_valid = 0, d3_req0_ready, d3_req1_ready, d3_rsp_ready = 1;
    logic [3:0] d3_req0_a = 0, d3_req0_b = 0;
    logic [2:0] d3_req0_sel = 0;
    logic [3:0] d3_alu_a, d3_alu_b;
    logic [2:0] d3_alu_sel;
    logic [7:0] d3_alu_out, d3_rsp_out, d3_op_count;
    logic       d3_alu_cflag, d3_alu_zflag;
    logic       d3_rsp_valid, d3_rsp_id, d3_rsp_cflag, d3_rsp_zflag, d3_rsp_err, d3_busy;

    // Stub ALU: returns {carry, zero, out[7:0]}.
    // 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 xor, 110 nand, 111 or.
    function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        logic [7:0] o;
        logic [4:0] s5;
        logic       c;
        c  = 1'b0;
        s5 = {1'b0, a} + {1'b0, b};
        case (sel)
            3'd0: begin o = {3'b0, s5}; c = s5[4]; end
            3'd1: begin o = {4'b0, a - b}; c = (a < b); end
            3'd2: o = {4'b0, a} * {4'b0, b};
            3'd3: begin
                if (b == 4'd0) begin o = 8'hFF; c = 1'b1; end  // garbage the DUT must ignore
                else o = {4'b0, a / b};
            end
            3'd4: o = {4'b0, a & b};
            3'd5: o = {4'b0, a ^ b};
            3'd6: o = {4'b0, ~(a & b)};
            default: o = {4'b0, a | b};
        endcase
        return {c, (o == 8'd0), o};
    endfunction

    assign {alu_cflag, alu_zflag, alu_out}          = alu_f(alu_a, alu_b, alu_sel);
    assign {d3_alu_cflag, d3_alu_zflag, d3_alu_out} = alu_f(d3_alu_a, d3_alu_b, d3_alu_sel);

    alu_arbiter #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_sel(req0_sel), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_cflag(alu_cflag), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_cflag(rsp_cflag), .rsp_zflag(rsp_zflag), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.SETTLE_CYCLES(S3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d3_req0_valid), .req1_valid(1'b0),
        .req0_ready(d3_req0_ready), .req1_ready(d3_req1_ready),
        .req0_a(d3_req0_a), .req0_b(d3_req0_b), .req1_a(4'd0), .req1_b(4'd0),
        .req0_sel(d3_req0_sel), .req1_sel(3'd0),
        .alu_a(d3_alu_a), .alu_b(d3_alu_b), .alu_sel(d3_alu_sel),
        .alu_out(d3_alu_out), .alu_cflag(d3_alu_cflag), .alu_zflag(d3_alu_zflag),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
        .rsp_out(d3_rsp_out), .rsp_cflag(d3_rsp_cflag), .rsp_zflag(d3_rsp_zflag), .rsp_err(d3_rsp_err),
        .busy(d3_busy), .op_count(d3_op_count)
    );

    typedef struct packed {
        logic       id;
        logic [7:0] out;
        logic       c;
        logic       z;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } pat_t;

    exp_t       sb[$];
    int         grants[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic       prev_rv = 1'b0;
    bit         acc_flag = 1'b0;

    function automatic exp_t mk_exp(input logic id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        exp_t       e;
        logic [9:0] r;
        r = alu_f(a, b, sel);
        if (sel == 3'b011 && b == 4'd0) e = '{id: id, out: 8'h00, c: 1'b0, z: 1'b0, err: 1'b1};
        else                            e = '{id: id, out: r[7:0], c: r[9], z: r[8], err: 1'b0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes mid-cycle, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        bit   hs;
        @(negedge clk);
        acc_flag = 1'b0;
        if (req0_ready || req1_ready) chk("one_ready", {31'b0, req0_ready & req1_ready}, 0);
        if (rsp_valid) chk("ready_in_resp", {31'b0, req0_ready | req1_ready}, 0);
        // rsp_valid must rise S+1 edges after the accepting edge; in tick units that is S+2.
        if (rsp_valid && !prev_rv) chk("latency", cyc - acc_cyc, S + 2);
        prev_rv = rsp_valid;
        if (req0_valid && req0_ready) begin
            sb.push_back(mk_exp(1'b0, req0_a, req0_b, req0_sel));
            grants.push_back(0);
            acc_cyc  = cyc;
            acc_flag = 1'b1;
        end
        if (req1_valid && req1_ready) begin
            sb.push_back(mk_exp(1'b1, req1_a, req1_b, req1_sel));
            grants.push_back(1);
            acc_cyc  = cyc;
            acc_flag = 1'b1;
        end
        hs = rsp_valid && rsp_ready;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_out", rsp_out, e.out);
                chk("rsp_cflag", rsp_cflag, e.c);
                chk("rsp_zflag", rsp_zflag, e.z);
                chk("rsp_err", rsp_err, e.err);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            exp_cnt++;
            chk("op_count", op_count, exp_cnt);
        end
    endtask

    task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
        bit got;
        got = 1'b0;
        if (id == 1'b0) begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
        else            begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = acc_flag;
        end
        if (!got) chk("accept_timeout", 0, 1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (sb.size() != 0 || busy); i++) tick();
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pat_t pats[7];
        logic [7:0] s_out, s_aa, s_ab;
        logic [2:0] s_sel;
        logic       s_id;
        int         n;
        bit         got;

        pats = '{ {1'b1, 4'd15, 4'd1, 3'd0}, {1'b0, 4'd3, 4'd5, 3'd1}, {1'b1, 4'd12, 4'd4, 3'd3},
                  {1'b0, 4'd10, 4'd5, 3'd4}, {1'b1, 4'd9, 4'd6, 3'd5}, {1'b0, 4'd0, 4'd0, 3'd6},
                  {1'b1, 4'd4, 4'd2, 3'd7} };

        // Reset state, with both requesters asserting valid.
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_rsp", {rsp_id, rsp_out, rsp_cflag, rsp_zflag, rsp_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", {31'b0, req0_ready | req1_ready}, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single request: 5 + 3.
        issue(1'b0, 4'd5, 4'd3, 3'd0);
        drain();
        chk("op_count_first", op_count, 1);

        // Reset during SETTLE abandons the operation and resets the pointer to requester 0.
        issue(1'b0, 4'd7, 4'd2, 3'd0);
        chk("in_settle", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_op_count", op_count, 0);
        sb.delete();
        grants.delete();
        exp_cnt = 8'd0;
        prev_rv = 1'b0;
        req0_a = 4'd5;  req0_b = 4'd3; req0_sel = 3'd0;
        req1_a = 4'd12; req1_b = 4'd4; req1_sel = 3'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both valid continuously, grants must alternate from requester 0.
        for (int i = 0; i < 60 && grants.size() < 4; i++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("grant_count", grants.size() >= 4, 1);
        if (grants.size() >= 4) begin
            chk("grant0", grants[0], 0);
            chk("grant1", grants[1], 1);
            chk("grant2", grants[2], 0);
            chk("grant3", grants[3], 1);
        end
        drain();

        // Divide by zero on requester 1.
        issue(1'b1, 4'd9, 4'd0, 3'b011);
        drain();

        // Backpressure: response and ALU drive held while rsp_ready stays low.
        rsp_ready = 1'b0;
        issue(1'b0, 4'd15, 4'd15, 3'd2);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        chk("bp_rsp_valid", rsp_valid, 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        s_out = rsp_out; s_id = rsp_id;
        s_aa = {4'd0, alu_a}; s_ab = {4'd0, alu_b}; s_sel = alu_sel;
        chk("bp_out", rsp_out, 8'hE1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_out", rsp_out, s_out);
            chk("bp_hold_id", rsp_id, s_id);
            chk("bp_hold_alu", {alu_a, alu_b, alu_sel}, {s_aa[3:0], s_ab[3:0], s_sel});
            chk("bp_busy", busy, 1);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Assorted opcodes and flag cases from both requesters.
        foreach (pats[k]) begin
            issue(pats[k].id, pats[k].a, pats[k].b, pats[k].sel);
            drain();
        end

        // Run on to 256 completions since the last reset: op_count wraps to 0.
        for (int i = 0; i < 300 && exp_cnt != 8'd0; i++) begin
            issue(i[0], i[3:0], 4'd1, 3'd0);
            drain();
        end
        chk("op_count_wrap", op_count, 0);

        // SETTLE_CYCLES=3 instance: rsp_valid four edges after the accepting edge.
        d3_req0_a = 4'd6; d3_req0_b = 4'd2; d3_req0_sel = 3'd0;
        d3_req0_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = d3_req0_ready;
            if (!got) @(posedge clk);
        end
        chk("d3_accept", got, 1);
        @(posedge clk);
        #1;
        d3_req0_valid = 1'b0;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            n++;
            got = d3_rsp_valid;
        end
        chk("d3_latency", n, S3 + 2);
        chk("d3_rsp_out", d3_rsp_out, 8'h08);
        chk("d3_flags", {d3_rsp_id, d3_rsp_cflag, d3_rsp_zflag, d3_rsp_err}, 0);
        chk("d3_busy", d3_busy, 1);
        chk("d3_ready1", d3_req1_ready, 0);
        @(posedge clk);
        #1;
        chk("d3_op_count", d3_op_count, 1);
        chk("d3_idle", d3_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
